// File: rtl/ckta_pkg.sv
// Shared definitions for the PGA channel sequencer: FSM states, CTRL
// register bit positions and the register-map address of CTRL.
package ckta_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AZ,
        ST_SETTLE,
        ST_SAMPLE
    } state_t;

    localparam int CTRL_RUN       = 0;
    localparam int CTRL_AUTORANGE = 1;
    localparam int ADDR_CTRL      = 0;

endpackage

// File: rtl/ckta_phase_timer.sv
// Loadable down-counter that times the auto-zero and settling phases.
// done is high while the count sits at zero.
module ckta_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Count register: load has priority, otherwise count down to zero and stop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/ckta_pga_seq.sv
// Instrumentation-amplifier input sequencer: scans N_CH channels through
// auto-zero, settle and sample phases, applies a per-channel PGA gain code,
// records overrange per channel and optionally steps the gain down.
module ckta_pga_seq
    import ckta_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int GAIN_W     = 3,
    parameter int AZ_CYC     = 4,
    parameter int SETTLE_CYC = 8,
    localparam int ADDR_W    = $clog2(N_CH + 1),
    localparam int CH_W      = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              ovr_in,
    output logic [N_CH-1:0]   ch_sel,
    output logic [GAIN_W-1:0] gain_code,
    output logic              az_en,
    output logic              sample_strobe,
    output logic [CH_W-1:0]   cur_ch,
    output logic [N_CH-1:0]   ovr_flag,
    output logic              busy
);

    localparam int T_MAX = (AZ_CYC > SETTLE_CYC) ? AZ_CYC : SETTLE_CYC;
    localparam int TW    = $clog2(T_MAX + 1);

    state_t            state, state_d;
    logic              ctrl_run, ctrl_ar;
    logic [GAIN_W-1:0] gain [N_CH];
    logic [CH_W-1:0]   cur_ch_d;
    logic [N_CH-1:0]   ovr_d;
    logic              wr_ok, ctrl_wr, run_d, cur_gain_wr, ovr_hit;
    logic              tmr_load, tmr_en, tmr_done;
    logic [TW-1:0]     tmr_val;
    logic              unused_wr_data;

    assign wr_ok       = ena && wr_en;
    assign ctrl_wr     = wr_ok && (wr_addr == ADDR_W'(ADDR_CTRL));
    // RUN as it will be after this edge, so start and abort act on the write cycle.
    assign run_d       = ctrl_wr ? wr_data[CTRL_RUN] : ctrl_run;
    assign cur_gain_wr = wr_ok && (wr_addr == ADDR_W'(cur_ch) + ADDR_W'(1));
    assign ovr_hit     = ena && (state == ST_SAMPLE) && ovr_in;

    assign gain_code      = gain[cur_ch];
    assign busy           = (state != ST_IDLE);
    assign unused_wr_data = ^wr_data;

    // Register file: CTRL and per-channel gains; a host write beats autorange.
    always_ff @(posedge clk) begin
        // NOTE: the gain file is small and must read 0 after reset, so it is
        // reset explicitly rather than left to power-up contents.
        if (!rst_n) begin
            ctrl_run <= 1'b0;
            ctrl_ar  <= 1'b0;
            for (int i = 0; i < N_CH; i++) gain[i] <= '0;
        end else if (ena) begin
            if (ctrl_wr) begin
                ctrl_run <= wr_data[CTRL_RUN];
                ctrl_ar  <= wr_data[CTRL_AUTORANGE];
            end
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en && wr_addr == ADDR_W'(i + 1)) begin
                    gain[i] <= wr_data[GAIN_W-1:0];
                end else if (ovr_hit && ctrl_ar && cur_ch == CH_W'(i) && gain[i] != '0) begin
                    gain[i] <= gain[i] - 1'b1;
                end
            end
        end
    end

    // Overrange flags: a CTRL write clears them, a coincident new overrange still sets.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        ovr_d = ovr_flag;
        if (ctrl_wr) ovr_d = '0;
        if (ovr_hit) ovr_d[cur_ch] = 1'b1;
    end

    // Next-state logic: phase sequencing, timer control and channel advance.
    always_comb begin
        state_d  = state;
        cur_ch_d = cur_ch;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        if (ena) begin
            if (!run_d) begin
                state_d  = ST_IDLE;
                cur_ch_d = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state_d  = ST_AZ;
                        cur_ch_d = '0;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(AZ_CYC - 1);
                    end
                    ST_AZ: begin
                        if (tmr_done) begin
                            state_d  = ST_SETTLE;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(SETTLE_CYC - 1);
                        end else begin
                            tmr_en = 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        // A gain change on the connected channel needs a full re-settle.
                        if (cur_gain_wr) begin
                            tmr_load = 1'b1;
                            tmr_val  = TW'(SETTLE_CYC - 1);
                        end else if (tmr_done) begin
                            state_d = ST_SAMPLE;
                        end else begin
                            tmr_en = 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        state_d  = ST_AZ;
                        cur_ch_d = (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(AZ_CYC - 1);
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Registered outputs decoded from the next state; strobe is dropped while frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_sel        <= '0;
            az_en         <= 1'b0;
            sample_strobe <= 1'b0;
            cur_ch        <= '0;
            ovr_flag      <= '0;
        end else if (ena) begin
            cur_ch        <= cur_ch_d;
            ch_sel        <= (state_d == ST_SETTLE || state_d == ST_SAMPLE) ?
                             (N_CH'(1) << cur_ch_d) : '0;
            az_en         <= (state_d == ST_AZ);
            sample_strobe <= (state_d == ST_SAMPLE);
            ovr_flag      <= ovr_d;
        end else begin
            sample_strobe <= 1'b0;
        end
    end

    ckta_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

endmodule

// File: tb/tb_ckta_pga_seq.sv
// Bench for ckta_pga_seq: directed scenarios followed by random traffic,
// every cycle compared against a phase/elapsed-time model of the sequencer.
module tb_ckta_pga_seq;

    localparam int N_CH       = 4;
    localparam int GAIN_W     = 3;
    localparam int AZ_CYC     = 4;
    localparam int SETTLE_CYC = 8;
    localparam int ADDR_W     = 3;
    localparam int CH_W       = 2;

    localparam int M_IDLE   = 0;
    localparam int M_AZ     = 1;
    localparam int M_SETTLE = 2;
    localparam int M_SAMPLE = 3;

    logic              clk = 1'b0;
    logic              rst_n, ena, wr_en, ovr_in;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [N_CH-1:0]   ch_sel, ovr_flag;
    logic [GAIN_W-1:0] gain_code;
    logic              az_en, sample_strobe, busy;
    logic [CH_W-1:0]   cur_ch;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase, cycles spent in it (current one included), channel.
    int          m_phase, m_cnt, m_ch;
    int          m_gain [N_CH];
    bit          m_run, m_ar, m_strobe;
    bit [N_CH-1:0] m_ovr;

    always #5 clk = ~clk;

    ckta_pga_seq #(
        .N_CH(N_CH), .GAIN_W(GAIN_W), .AZ_CYC(AZ_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .ovr_in(ovr_in), .ch_sel(ch_sel), .gain_code(gain_code),
        .az_en(az_en), .sample_strobe(sample_strobe), .cur_ch(cur_ch),
        .ovr_flag(ovr_flag), .busy(busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = M_IDLE; m_cnt = 0; m_ch = 0;
        for (int i = 0; i < N_CH; i++) m_gain[i] = 0;
        m_run = 0; m_ar = 0; m_strobe = 0; m_ovr = '0;
    endtask

    // One clock of the model, from the inputs currently applied.
    task automatic model_step();
        bit ctrl_w, run_new, hit;
        int gidx, old_ch;
        if (!rst_n) begin
            model_reset();
        end else if (!ena) begin
            m_strobe = 0;
        end else begin
            ctrl_w = wr_en && (wr_addr == 0);
            gidx   = (wr_en && wr_addr >= 1 && wr_addr <= N_CH) ? int'(wr_addr) - 1 : -1;
            hit    = (m_phase == M_SAMPLE) && ovr_in;
            old_ch = m_ch;
            if (hit && m_ar && m_gain[old_ch] > 0) m_gain[old_ch] = m_gain[old_ch] - 1;
            if (gidx >= 0) m_gain[gidx] = int'(wr_data) % (1 << GAIN_W);
            if (ctrl_w) m_ovr = '0;
            if (hit) m_ovr[old_ch] = 1'b1;
            run_new = ctrl_w ? wr_data[0] : m_run;
            if (!run_new) begin
                m_phase = M_IDLE; m_cnt = 0; m_ch = 0;
            end else begin
                case (m_phase)
                    M_IDLE:   begin m_phase = M_AZ; m_cnt = 1; m_ch = 0; end
                    M_AZ:     if (m_cnt == AZ_CYC) begin m_phase = M_SETTLE; m_cnt = 1; end
                              else m_cnt++;
                    M_SETTLE: if (gidx == old_ch) m_cnt = 1;
                              else if (m_cnt == SETTLE_CYC) begin m_phase = M_SAMPLE; m_cnt = 1; end
                              else m_cnt++;
                    default:  begin m_ch = (m_ch + 1) % N_CH; m_phase = M_AZ; m_cnt = 1; end
                endcase
            end
            if (ctrl_w) begin m_run = wr_data[0]; m_ar = wr_data[1]; end
            m_strobe = (m_phase == M_SAMPLE);
        end
    endtask

    task automatic check_outputs();
        int exp_sel;
        exp_sel = (m_phase == M_SETTLE || m_phase == M_SAMPLE) ? (1 << m_ch) : 0;
        check("ch_sel", ch_sel, exp_sel);
        check("az_en", az_en, m_phase == M_AZ);
        check("sample_strobe", sample_strobe, m_strobe);
        check("cur_ch", cur_ch, m_ch);
        check("ovr_flag", ovr_flag, m_ovr);
        check("gain_code", gain_code, m_gain[m_ch]);
        check("busy", busy, m_phase != M_IDLE);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_tick();
        wr_en = 1'b0;
        tick();
    endtask

    task automatic write(input int addr, input int data);
        wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = 8'(data);
        tick();
        wr_en = 1'b0;
    endtask

    // Idle until the model is in the given phase (ch/cnt of -1 = any), bounded.
    task automatic wait_phase(input int ph, input int ch, input int cnt, input string tag);
        bit found = 0;
        for (int c = 0; c < 400; c++) begin
            if (m_phase == ph && (ch < 0 || m_ch == ch) && (cnt < 0 || m_cnt == cnt)) begin
                found = 1;
                break;
            end
            idle_tick();
        end
        check(tag, found, 1);
    endtask

    initial begin
        int strobe_at [5];
        int sel_at [5];
        int n_str, az_cnt, settle_cnt, hits, ch_at, n;
        int vis [7];
        logic [15:0] snap;

        rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; ovr_in = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_ch_sel", ch_sel, 0);

        // Start a scan and time one full period.
        write(0, 8'h01);
        check("start_busy", busy, 1);
        check("start_az", az_en, 1);
        n_str = 0; az_cnt = az_en; settle_cnt = 0;
        for (int k = 2; k <= 66; k++) begin
            idle_tick();
            if (k <= 13) begin
                az_cnt += az_en;
                if (ch_sel == 4'b0001 && !sample_strobe) settle_cnt++;
            end
            if (sample_strobe && n_str < 5) begin
                strobe_at[n_str] = k; sel_at[n_str] = ch_sel; n_str++;
            end
        end
        check("az_len", az_cnt, AZ_CYC);
        check("settle_len", settle_cnt, SETTLE_CYC);
        check("n_strobes", n_str, 5);
        check("first_strobe", strobe_at[0], 13);
        check("scan_period", strobe_at[4] - strobe_at[0], 52);
        check("sel_order0", sel_at[0], 4'b0001);
        check("sel_order1", sel_at[1], 4'b0010);
        check("sel_order2", sel_at[2], 4'b0100);
        check("sel_order3", sel_at[3], 4'b1000);
        check("sel_order4", sel_at[4], 4'b0001);
        write(0, 8'h00);

        // Overrange on channel 2 with autorange: gain steps 5 down to 0 and stays.
        write(3, 5);
        write(0, 8'h03);
        hits = 0;
        for (int c = 0; c < 1200 && hits < 7; c++) begin
            ovr_in = (m_phase == M_SAMPLE && m_ch == 2);
            if (ovr_in) vis[hits] = gain_code;
            idle_tick();
            if (ovr_in) begin
                hits++;
                if (hits == 1) check("ovr_flag_ch2", ovr_flag, 4'b0100);
            end
        end
        ovr_in = 1'b0;
        check("ovr_hits", hits, 7);
        check("ar_visit0", vis[0], 5);
        check("ar_visit1", vis[1], 4);
        check("ar_visit2", vis[2], 3);
        check("ar_visit5", vis[5], 0);
        check("ar_visit6", vis[6], 0);

        // CTRL write coincident with a channel-0 overrange: the new flag survives.
        wait_phase(M_SAMPLE, 0, -1, "wait_sample_ch0");
        ch_at = m_ch;
        ovr_in = 1'b1;
        write(0, 8'h03);
        ovr_in = 1'b0;
        check("clear_vs_set", ovr_flag, 1 << ch_at);

        // Gain write to the connected channel mid-settle restarts settling.
        wait_phase(M_SETTLE, 1, 5, "wait_settle_ch1");
        write(2, 3);
        check("gain_after_wr", gain_code, 3);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            idle_tick();
            n++;
            if (sample_strobe) break;
        end
        check("restart_delay", n, 8);

        // Abort mid-settle on channel 3, then restart from channel 0.
        wait_phase(M_SETTLE, 3, 3, "wait_settle_ch3");
        write(0, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_ch_sel", ch_sel, 0);
        check("abort_strobe", sample_strobe, 0);
        idle_tick();
        idle_tick();
        write(0, 8'h01);
        check("restart_ch", cur_ch, 0);
        check("restart_az", az_en, 1);

        // Freeze mid-AZ for ten cycles; a write attempted meanwhile is ignored.
        wait_phase(M_AZ, -1, 2, "wait_az2");
        snap = {ch_sel, gain_code, az_en, cur_ch, ovr_flag, busy, sample_strobe};
        ena = 1'b0; wr_en = 1'b1; wr_addr = '0; wr_data = 8'h00;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("frozen", {ch_sel, gain_code, az_en, cur_ch, ovr_flag, busy, sample_strobe}, snap);
        end
        wr_en = 1'b0; ena = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            idle_tick();
            if (!az_en) break;
            n++;
        end
        check("az_resume", n, 2);

        // Reset during SAMPLE together with a gain write.
        write(1, 6);
        wait_phase(M_SAMPLE, -1, -1, "wait_sample_rst");
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h07;
        tick();
        rst_n = 1'b1; wr_en = 1'b0;
        check("rst_ch_sel2", ch_sel, 0);
        check("rst_gain", gain_code, 0);
        check("rst_az", az_en, 0);
        check("rst_strobe", sample_strobe, 0);
        check("rst_busy2", busy, 0);
        check("rst_ovr", ovr_flag, 0);

        // Random traffic against the model.
        write(0, 8'h03);
        for (int c = 0; c < 3000; c++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            ena     = ($urandom_range(0, 9) != 0);
            wr_en   = ($urandom_range(0, 4) == 0);
            wr_addr = ADDR_W'($urandom_range(0, 7));
            wr_data = 8'($urandom);
            if (wr_addr == 0 && $urandom_range(0, 3) != 0) wr_data[0] = 1'b1;
            ovr_in  = $urandom_range(0, 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ckta_pga_seq.md
CKTA_PGA_SEQ -- requirements
Module: ckta_pga_seq

Interface
REQ-001 Parameter N_CH, default 4, number of multiplexed instrumentation-amplifier input channels (2..8).
REQ-002 Parameter GAIN_W, default 3, width of the per-channel PGA gain code.
REQ-003 Parameter AZ_CYC, default 4, auto-zero phase length in clk cycles (>=1).
REQ-004 Parameter SETTLE_CYC, default 8, post-switch settling length in clk cycles (>=1).
REQ-005 Derived ADDR_W = clog2(N_CH+1).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 ena  in  1  design enable; low freezes all state (hold), outputs keep last value.
REQ-009 wr_en  in  1  register write strobe, one write per cycle.
REQ-010 wr_addr  in  ADDR_W  0 = CTRL, 1..N_CH = GAIN[addr-1]; other addresses ignored.
REQ-011 wr_data  in  8  write data; CTRL bit0 RUN, bit1 AUTORANGE; GAIN uses bits [GAIN_W-1:0].
REQ-012 ovr_in  in  1  overrange comparator output from the analog amplifier, sampled only in SAMPLE.
REQ-013 ch_sel  out  N_CH  one-hot input-switch enables; all-zero when no channel connected.
REQ-014 gain_code  out  GAIN_W  gain code of the current channel.
REQ-015 az_en  out  1  auto-zero switch enable.
REQ-016 sample_strobe  out  1  one-cycle pulse: amplifier output valid for external ADC.
REQ-017 cur_ch  out  clog2(N_CH)  index of current channel.
REQ-018 ovr_flag  out  N_CH  sticky per-channel overrange flags; cleared by any write to CTRL.
REQ-019 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, AZ, SETTLE, SAMPLE.
REQ-021 IDLE: ch_sel=0, az_en=0; RUN=1 registered at edge t SHALL give AZ from cycle t+1 with cur_ch=0.
REQ-022 AZ: az_en=1, ch_sel=0, lasts exactly AZ_CYC cycles, then SETTLE.
REQ-023 SETTLE: ch_sel one-hot at cur_ch, az_en=0, lasts exactly SETTLE_CYC cycles, then SAMPLE.
REQ-024 SAMPLE: one cycle, sample_strobe=1, ch_sel held; then cur_ch advances (N_CH-1 wraps to 0) and FSM enters AZ.
REQ-025 gain_code SHALL equal GAIN[cur_ch] combinationally from the register file in every state.
REQ-026 In SAMPLE with ovr_in=1: ovr_flag[cur_ch] set; if AUTORANGE=1 and GAIN[cur_ch]>0, GAIN[cur_ch] decremented by 1 (saturate at 0).
REQ-027 Write to GAIN[cur_ch] during SETTLE SHALL restart the settle counter (full SETTLE_CYC from next cycle).
REQ-028 Write to GAIN[cur_ch] in the same cycle as an autorange decrement: write wins.
REQ-029 RUN cleared by write SHALL abort: next cycle IDLE, ch_sel=0, az_en=0, sample_strobe=0; cur_ch reset to 0.
REQ-030 RUN rewritten to 1 while running SHALL not restart the sequence; CTRL write still clears ovr_flag.
REQ-031 CTRL write clearing ovr_flag coincident with a SAMPLE overrange: the new set wins.
REQ-032 ena=0 SHALL block register writes, counters and FSM transitions; sample_strobe forced 0 while ena=0.

Reset
REQ-033 rst_n=0 at an edge: state IDLE, counters 0, CTRL=0, all GAIN=0, ovr_flag=0, cur_ch=0.
REQ-034 Output reset values: ch_sel=0, gain_code=0, az_en=0, sample_strobe=0, busy=0, ovr_flag=0.
REQ-035 Reset SHALL override ena and any simultaneous write; reset mid-sequence lands directly in IDLE.

Structure
REQ-036 Shared package ckta_pkg holds the state enum, CTRL bit positions and ADDR_CTRL constant.
REQ-037 One sub-module ckta_phase_timer: loadable down-counter with load, enable and done (count==0) used for AZ and SETTLE.
REQ-038 All outputs registered except gain_code (register-file read) and busy.

Verification (N_CH=4, GAIN_W=3, AZ_CYC=4, SETTLE_CYC=8)
REQ-039 Write CTRL=0x01 -> busy next cycle, az_en high 4 cycles, ch_sel=0001 8 cycles, one sample_strobe; full 4-channel scan period 52 cycles, ch_sel order 0001,0010,0100,1000,0001.
REQ-040 GAIN[2]=5, CTRL=0x03, ovr_in=1 during ch2 SAMPLE -> ovr_flag=0100, GAIN[2]=4 on next visit, repeated overrange saturates at 0.
REQ-041 Write GAIN[1]=3 at settle cycle 5 of ch1 -> gain_code=3 next cycle, sample_strobe 8 cycles after the write, not 3.
REQ-042 Write CTRL=0x00 mid-SETTLE on ch3 -> next cycle IDLE, ch_sel=0000, no strobe; rewrite 0x01 restarts at ch0.
REQ-043 ena=0 for 10 cycles mid-AZ -> all outputs frozen, az_en still high, AZ completes remaining cycles after ena=1.
REQ-044 rst_n=0 one cycle during SAMPLE with concurrent GAIN write -> all outputs at reset values, GAIN reads 0.
